mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the mips1 datapath; the issuing end of the ALU
//  alu_op/Zero interface. Decodes the latched instruction and sequences
//  FETCH/DECODE/EXECUTE/MEM/WRITEBACK. Drives alu_op, mux selects and the
//  register/memory/PC enables, and waits on a memory ready handshake.
// PARAMETERS
//  OP_W      5    alu_op width; codes NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOR=6
//  WAIT_MAX  255  max consecutive mem_ready=0 cycles in a wait state; 0 = never time out
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     synchronous reset, active-high
//  opcode       in   6     instr[31:26] from IR
//  funct        in   6     instr[5:0] from IR
//  alu_zero     in   1     ALU Zero output (signed alu_a > 0)
//  mem_ready    in   1     memory completes current read/write this cycle
//  alu_op       out  OP_W  ALU operation code
//  alu_src_a    out  1     0=PC, 1=rs
//  alu_src_b    out  2     0=rt, 1=const 4, 2=ext imm, 3=sext imm<<2
//  imm_zext     out  1     1=zero-extend imm (andi/ori/xori), 0=sign-extend
//  pc_write     out  1     PC load enable
//  pc_src       out  2     0=alu_out, 1=target reg, 2={PC[31:28],instr[25:0],2'b00}
//  target_write out  1     load branch-target register from alu_out
//  ir_write     out  1     IR load enable
//  iord         out  1     memory address: 0=PC, 1=alu_out reg
//  mem_rd       out  1     memory read request
//  mem_wr       out  1     memory write request
//  reg_write    out  1     register file write enable
//  reg_dst      out  1     0=rt, 1=rd
//  mem_to_reg   out  1     0=alu_out, 1=MDR
//  illegal      out  1     1-cycle pulse: unsupported opcode/funct
//  bus_err      out  1     1-cycle pulse: mem_ready timeout
//  state_o      out  4     current state encoding (debug)
// BEHAVIOUR
//  States: RST=0 FETCH=1 DECODE=2 EXEC_R=3 EXEC_I=4 ADDR=5 MEM_RD=6 MEM_WB=7
//   MEM_WR=8 ALU_WB=9 BRANCH=10 JUMP=11. rst (any state, mid-instr) -> RST next edge.
//  RST: every output 0, state_o=0; next FETCH unconditionally.
//  Unlisted outputs are 0 in every state. Moore outputs, except pc_write/ir_write
//   in FETCH, which are gated by mem_ready.
//  FETCH: mem_rd=1 iord=0 src_a=0 src_b=1 alu_op=ADD; when mem_ready: ir_write=1,
//   pc_write=1 pc_src=0, -> DECODE; else stay.
//  DECODE: src_a=0 src_b=3 alu_op=ADD target_write=1. Dispatch on opcode:
//   000000 -> EXEC_R if funct in {20,21:ADD 22,23:SUB 24:AND 25:OR 26:XOR 27:NOR} (hex)
//   08/09 addi/addiu, 0C andi, 0D ori, 0E xori -> EXEC_I; 23 lw, 2B sw -> ADDR;
//   07 bgtz -> BRANCH; 02 j -> JUMP; else illegal=1 -> FETCH.
//  EXEC_R: src_a=1 src_b=0, alu_op per funct -> ALU_WB with reg_dst=1.
//  EXEC_I: src_a=1 src_b=2, imm_zext=1 for 0C/0D/0E; ADD/AND/OR/XOR -> ALU_WB, reg_dst=0.
//  ALU_WB: reg_write=1 mem_to_reg=0, reg_dst held from exec class -> FETCH.
//  ADDR: src_a=1 src_b=2 alu_op=ADD -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: mem_rd=1 iord=1; mem_ready -> MEM_WB. MEM_WB: reg_write=1 mem_to_reg=1
//   reg_dst=0 -> FETCH.
//  MEM_WR: mem_wr=1 iord=1; mem_ready -> FETCH.
//  BRANCH: src_a=1 alu_op=NOP; pc_src=1, pc_write=alu_zero -> FETCH.
//  JUMP: pc_write=1 pc_src=2 -> FETCH.
//  Wait counter: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0, clears on
//   state change or mem_ready=1; reaching WAIT_MAX: bus_err=1 for one cycle,
//   counter clears, -> FETCH (no pc_write, no reg_write).
//  mem_ready ignored outside wait states. alu_op never takes codes >6.
// TESTING
//  rst 3 cycles then release -> all outputs 0 during rst; state RST->FETCH; mem_rd=1, alu_op=1.
//  R-type 000000/funct 22, mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_op=2),ALU_WB(reg_write=1,reg_dst=1): 4 cycles.
//  lw (23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB mem_to_reg=1.
//  bgtz (07) with alu_zero=0 then =1 -> pc_write 0 then 1, pc_src=1 both times.
//  opcode 3F -> illegal pulse in DECODE, back to FETCH, no reg/mem writes.
//  WAIT_MAX=4, mem_ready stuck 0 in MEM_WR -> bus_err on 4th wait cycle, next FETCH; rst mid-ADDR -> RST.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the mips1 multicycle controller.
// master = controller side, slave = datapath/memory side.
interface mips_ctrl_if #(
   parameter int OP_W = 5
);
   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic            alu_zero;
   logic            mem_ready;
   logic [OP_W-1:0] alu_op;
   logic            alu_src_a;
   logic [1:0]      alu_src_b;
   logic            imm_zext;
   logic            pc_write;
   logic [1:0]      pc_src;
   logic            target_write;
   logic            ir_write;
   logic            iord;
   logic            mem_rd;
   logic            mem_wr;
   logic            reg_write;
   logic            reg_dst;
   logic            mem_to_reg;
   logic            illegal;
   logic            bus_err;
   logic [3:0]      state_o;

   modport master (
      input  opcode, funct, alu_zero, mem_ready,
      output alu_op, alu_src_a, alu_src_b, imm_zext, pc_write, pc_src,
             target_write, ir_write, iord, mem_rd, mem_wr, reg_write,
             reg_dst, mem_to_reg, illegal, bus_err, state_o
   );

   modport slave (
      output opcode, funct, alu_zero, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, imm_zext, pc_write, pc_src,
             target_write, ir_write, iord, mem_rd, mem_wr, reg_write,
             reg_dst, mem_to_reg, illegal, bus_err, state_o
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the mips1 datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, issues alu_op, and waits on the
// memory ready handshake with an optional timeout.
module mips_multicycle_ctrl #(
   parameter int OP_W     = 5,
   parameter int WAIT_MAX = 255
) (
   input  logic      clk,
   input  logic      rst,
   mips_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WB = 4'd7,
      S_MEM_WR = 4'd8,
      S_ALU_WB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] ALU_NOP = OP_W'(0);
   localparam logic [OP_W-1:0] ALU_ADD = OP_W'(1);
   localparam logic [OP_W-1:0] ALU_SUB = OP_W'(2);
   localparam logic [OP_W-1:0] ALU_AND = OP_W'(3);
   localparam logic [OP_W-1:0] ALU_OR  = OP_W'(4);
   localparam logic [OP_W-1:0] ALU_XOR = OP_W'(5);
   localparam logic [OP_W-1:0] ALU_NOR = OP_W'(6);

   // Counter only has to reach WAIT_MAX-1; the timeout fires on that cycle.
   localparam int              CNT_W      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST  = (WAIT_MAX == 0) ? '0 : CNT_W'(WAIT_MAX - 1);
   localparam bit              TIMEOUT_EN = (WAIT_MAX != 0);

   state_t           state, state_nx;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_state;
   logic             timeout;
   logic             r_type_dst;
   logic             r_legal;
   logic [OP_W-1:0]  r_op;
   logic [OP_W-1:0]  i_op;
   logic             i_zext;

   assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timeout    = TIMEOUT_EN && wait_state && !bus.mem_ready && (wait_cnt == CNT_LAST);

   // Instruction field decode: ALU operation for R-type funct and I-type opcode.
   always_comb begin
      r_legal = 1'b1;
      r_op    = ALU_NOP;
      case (bus.funct)
         6'h20, 6'h21: r_op = ALU_ADD;
         6'h22, 6'h23: r_op = ALU_SUB;
         6'h24:        r_op = ALU_AND;
         6'h25:        r_op = ALU_OR;
         6'h26:        r_op = ALU_XOR;
         6'h27:        r_op = ALU_NOR;
         default:      r_legal = 1'b0;
      endcase
      i_zext = 1'b0;
      i_op   = ALU_NOP;
      case (bus.opcode)
         6'h08, 6'h09: i_op = ALU_ADD;
         6'h0C: begin i_op = ALU_AND; i_zext = 1'b1; end
         6'h0D: begin i_op = ALU_OR;  i_zext = 1'b1; end
         6'h0E: begin i_op = ALU_XOR; i_zext = 1'b1; end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_RST;
      else     state <= state_nx;
   end

   // Memory wait counter: runs only while stalled in a wait state.
   always_ff @(posedge clk) begin
      if (rst)                                    wait_cnt <= '0;
      else if (wait_state && !bus.mem_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                        wait_cnt <= '0;
   end

   // Remember whether the instruction in flight writes rd (R-type) or rt.
   always_ff @(posedge clk) begin
      if (rst)                    r_type_dst <= 1'b0;
      else if (state == S_EXEC_R) r_type_dst <= 1'b1;
      else if (state == S_EXEC_I) r_type_dst <= 1'b0;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_RST:    state_nx = S_FETCH;
         S_FETCH:  if (timeout) state_nx = S_FETCH;
                   else if (bus.mem_ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               6'h00:                             state_nx = r_legal ? S_EXEC_R : S_FETCH;
               6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: state_nx = S_EXEC_I;
               6'h23, 6'h2B:                      state_nx = S_ADDR;
               6'h07:                             state_nx = S_BRANCH;
               6'h02:                             state_nx = S_JUMP;
               default:                           state_nx = S_FETCH;
            endcase
         end
         S_EXEC_R: state_nx = S_ALU_WB;
         S_EXEC_I: state_nx = S_ALU_WB;
         S_ALU_WB: state_nx = S_FETCH;
         S_ADDR:   state_nx = (bus.opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: if (timeout) state_nx = S_FETCH;
                   else if (bus.mem_ready) state_nx = S_MEM_WB;
         S_MEM_WB: state_nx = S_FETCH;
         S_MEM_WR: if (timeout || bus.mem_ready) state_nx = S_FETCH;
         S_BRANCH: state_nx = S_FETCH;
         S_JUMP:   state_nx = S_FETCH;
         default:  state_nx = S_RST;
      endcase
   end

   // Output logic: Moore per state, except the FETCH enables gated by mem_ready.
   always_comb begin
      bus.alu_op       = ALU_NOP;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = 2'd0;
      bus.imm_zext     = 1'b0;
      bus.pc_write     = 1'b0;
      bus.pc_src       = 2'd0;
      bus.target_write = 1'b0;
      bus.ir_write     = 1'b0;
      bus.iord         = 1'b0;
      bus.mem_rd       = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.reg_write    = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.illegal      = 1'b0;
      bus.bus_err      = timeout;
      bus.state_o      = state;
      case (state)
         S_FETCH: begin
            bus.mem_rd    = 1'b1;
            bus.alu_src_b = 2'd1;
            bus.alu_op    = ALU_ADD;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_b    = 2'd3;
            bus.alu_op       = ALU_ADD;
            bus.target_write = 1'b1;
            bus.illegal      = (state_nx == S_FETCH);
         end
         S_EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = r_op;
         end
         S_EXEC_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.imm_zext  = i_zext;
            bus.alu_op    = i_op;
         end
         S_ALU_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = r_type_dst;
         end
         S_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            bus.mem_rd = 1'b1;
            bus.iord   = 1'b1;
         end
         S_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            bus.mem_wr = 1'b1;
            bus.iord   = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.pc_src    = 2'd1;
            bus.pc_write  = bus.alu_zero;
         end
         S_JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd2;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios followed
// by randomized instruction streams against an instruction-level model.
module tb_mips_multicycle_ctrl;
   localparam int WMAX = 4;

   localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3,
                  ST_EXEC_I = 4, ST_ADDR = 5, ST_MEM_RD = 6, ST_MEM_WB = 7,
                  ST_MEM_WR = 8, ST_ALU_WB = 9, ST_BRANCH = 10, ST_JUMP = 11;

   localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5, C_J = 6;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mips_ctrl_if #(.OP_W(5)) bus ();

   mips_multicycle_ctrl #(.OP_W(5), .WAIT_MAX(WMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction class from the ISA subset supported by the controller.
   function automatic int class_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:                             return (fn >= 6'h20 && fn <= 6'h27) ? C_R : C_ILL;
         6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: return C_I;
         6'h23:                             return C_LW;
         6'h2B:                             return C_SW;
         6'h07:                             return C_BR;
         6'h02:                             return C_J;
         default:                           return C_ILL;
      endcase
   endfunction

   function automatic logic [4:0] r_code(input logic [5:0] fn);
      if (fn < 6'h22) return 5'd1;
      if (fn < 6'h24) return 5'd2;
      return 5'(fn - 6'h24 + 6'd3);
   endfunction

   function automatic logic [4:0] i_code(input logic [5:0] op);
      case (op)
         6'h0C:   return 5'd3;
         6'h0D:   return 5'd4;
         6'h0E:   return 5'd5;
         default: return 5'd1;
      endcase
   endfunction

   // Expected output vector for one cycle in a given step of an instruction.
   function automatic logic [31:0] model(input int st, input logic [5:0] op, input logic [5:0] fn,
                                         input logic zero, input logic ready, input logic berr);
      logic [4:0] aop; logic sa; logic [1:0] sb; logic zx; logic pw; logic [1:0] ps;
      logic tw, iw, io, mr, mw, rw, rd, m2r, ill;
      aop = 5'd0; sa = 1'b0; sb = 2'd0; zx = 1'b0; pw = 1'b0; ps = 2'd0;
      tw = 1'b0; iw = 1'b0; io = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
      case (st)
         ST_FETCH:  begin mr = 1'b1; sb = 2'd1; aop = 5'd1; iw = ready; pw = ready; end
         ST_DECODE: begin sb = 2'd3; aop = 5'd1; tw = 1'b1; ill = (class_of(op, fn) == C_ILL); end
         ST_EXEC_R: begin sa = 1'b1; aop = r_code(fn); end
         ST_EXEC_I: begin sa = 1'b1; sb = 2'd2; aop = i_code(op); zx = (op == 6'h0C || op == 6'h0D || op == 6'h0E); end
         ST_ALU_WB: begin rw = 1'b1; rd = (op == 6'h00); end
         ST_ADDR:   begin sa = 1'b1; sb = 2'd2; aop = 5'd1; end
         ST_MEM_RD: begin mr = 1'b1; io = 1'b1; end
         ST_MEM_WB: begin rw = 1'b1; m2r = 1'b1; end
         ST_MEM_WR: begin mw = 1'b1; io = 1'b1; end
         ST_BRANCH: begin sa = 1'b1; ps = 2'd1; pw = zero; end
         ST_JUMP:   begin pw = 1'b1; ps = 2'd2; end
         default: ;
      endcase
      return 32'({4'(st), aop, sa, sb, zx, pw, ps, tw, iw, io, mr, mw, rw, rd, m2r, ill, berr});
   endfunction

   function automatic logic [31:0] observed();
      return 32'({bus.state_o, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.imm_zext,
                  bus.pc_write, bus.pc_src, bus.target_write, bus.ir_write, bus.iord,
                  bus.mem_rd, bus.mem_wr, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                  bus.illegal, bus.bus_err});
   endfunction

   // One clock: compare at the falling edge, then advance past the rising edge.
   task automatic cyc(input int st, input logic berr, input string tag);
      @(negedge clk);
      check(tag, observed(), model(st, bus.opcode, bus.funct, bus.alu_zero, bus.mem_ready, berr));
      @(posedge clk);
      #1;
   endtask

   // Non-wait step: handshake inputs are don't-care, so scramble them.
   task automatic step(input int st, input string tag);
      bus.mem_ready = 1'($urandom);
      bus.alu_zero  = 1'($urandom);
      cyc(st, 1'b0, tag);
   endtask

   // Wait state: n_wait stalled cycles (n_wait < WMAX) then the ready cycle.
   task automatic mem_wait(input int st, input int n_wait, input string tag);
      for (int i = 0; i < n_wait; i++) begin
         bus.mem_ready = 1'b0;
         bus.alu_zero  = 1'($urandom);
         cyc(st, 1'b0, {tag, "_stall"});
      end
      bus.mem_ready = 1'b1;
      cyc(st, 1'b0, {tag, "_ready"});
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                            input int n_fetch, input int n_mem);
      int cls;
      bus.opcode = op;
      bus.funct  = fn;
      cls = class_of(op, fn);
      mem_wait(ST_FETCH, n_fetch, "fetch");
      step(ST_DECODE, "decode");
      case (cls)
         C_R:  begin step(ST_EXEC_R, "exec_r"); step(ST_ALU_WB, "alu_wb_r"); end
         C_I:  begin step(ST_EXEC_I, "exec_i"); step(ST_ALU_WB, "alu_wb_i"); end
         C_LW: begin step(ST_ADDR, "addr_lw"); mem_wait(ST_MEM_RD, n_mem, "mem_rd"); step(ST_MEM_WB, "mem_wb"); end
         C_SW: begin step(ST_ADDR, "addr_sw"); mem_wait(ST_MEM_WR, n_mem, "mem_wr"); end
         C_BR: begin
            bus.mem_ready = 1'($urandom);
            bus.alu_zero  = zero;
            cyc(ST_BRANCH, 1'b0, "branch");
         end
         C_J:  step(ST_JUMP, "jump");
         default: ;
      endcase
   endtask

   logic [5:0] op_pool [10] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h07, 6'h02};

   initial begin
      logic [5:0] op, fn;
      rst = 1'b1;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(ST_RST, "reset_hold");
      rst = 1'b0;
      step(ST_RST, "reset_release");

      // R-type SUB, no memory stalls.
      run_instr(6'h00, 6'h22, 1'b0, 0, 0);
      // lw with three stalled cycles in MEM_RD.
      run_instr(6'h23, 6'h00, 1'b0, 0, 3);
      // bgtz not taken, then taken.
      run_instr(6'h07, 6'h00, 1'b0, 0, 0);
      run_instr(6'h07, 6'h00, 1'b1, 0, 0);
      // Unsupported opcode and unsupported funct.
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
      run_instr(6'h00, 6'h2A, 1'b0, 0, 0);
      // Zero-extended immediate forms.
      run_instr(6'h0C, 6'h00, 1'b0, 1, 0);
      run_instr(6'h0E, 6'h00, 1'b0, 0, 0);

      // sw with mem_ready stuck low: bus_err on the WMAX-th stalled cycle.
      bus.opcode = 6'h2B; bus.funct = 6'h00;
      mem_wait(ST_FETCH, 0, "to_fetch");
      step(ST_DECODE, "to_decode");
      step(ST_ADDR, "to_addr");
      for (int i = 0; i < WMAX; i++) begin
         bus.mem_ready = 1'b0;
         cyc(ST_MEM_WR, (i == WMAX - 1), "to_mem_wr");
      end
      // Timeout in FETCH: stays in FETCH, then proceeds normally.
      for (int i = 0; i < WMAX; i++) begin
         bus.mem_ready = 1'b0;
         cyc(ST_FETCH, (i == WMAX - 1), "to_fetch_stuck");
      end
      run_instr(6'h02, 6'h00, 1'b0, 2, 0);

      // Reset asserted while in ADDR.
      bus.opcode = 6'h23; bus.funct = 6'h00;
      mem_wait(ST_FETCH, 0, "rstmid_fetch");
      step(ST_DECODE, "rstmid_decode");
      rst = 1'b1;
      step(ST_ADDR, "rstmid_addr");
      rst = 1'b0;
      step(ST_RST, "rstmid_rst");

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else                           op = op_pool[$urandom_range(0, 9)];
         fn = (op == 6'h00) ? 6'($urandom_range(6'h1C, 6'h2B)) : 6'($urandom);
         run_instr(op, fn, 1'($urandom), $urandom_range(0, WMAX - 1), $urandom_range(0, WMAX - 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
